// File: rtl/irq_source_ctrl_if.sv
// Word-wide register access port between the data-memory decode and the
// interrupt source controller.
interface irq_source_ctrl_if;
    logic        bus_sel;
    logic        bus_wr;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;

    modport master (
        output bus_sel,
        output bus_wr,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_rvalid
    );

    modport slave (
        input  bus_sel,
        input  bus_wr,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_rvalid
    );
endinterface

// File: rtl/irq_source_ctrl.sv
// Machine timer plus synchronized external interrupt, encoded into the 4-bit
// interrupt code sampled every cycle by the CSR block.
module irq_source_ctrl #(
    parameter int unsigned PRESCALE = 1,
    parameter bit          EXT_EDGE = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_irq,
    irq_source_ctrl_if.slave   bus,
    output logic [3:0]         interrupt
);

    localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

    localparam logic [2:0] AddrMtimeLo = 3'd0;
    localparam logic [2:0] AddrMtimeHi = 3'd1;
    localparam logic [2:0] AddrCmpLo   = 3'd2;
    localparam logic [2:0] AddrCmpHi   = 3'd3;
    localparam logic [2:0] AddrStatus  = 3'd4;
    localparam logic [2:0] AddrCtrl    = 3'd5;

    logic [15:0] cnt_q, cnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        pend_q, pend_d;
    logic        tp_q;
    logic        sync1_q, sync2_q, sync3_q;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;
    logic [3:0]  irq_q, irq_d;

    logic        wr_en, rd_en, ext_pend, unused_addr;
    logic [2:0]  word;

    assign wr_en       = bus.bus_sel & bus.bus_wr;
    assign rd_en       = bus.bus_sel & ~bus.bus_wr;
    assign word        = bus.bus_addr[4:2];
    assign unused_addr = ^bus.bus_addr[1:0];

    // Level mode bypasses the pending latch so latency stays at the two sync flops.
    assign ext_pend = EXT_EDGE ? pend_q : sync2_q;

    always_comb begin
        cnt_d    = cnt_q;
        mtime_d  = mtime_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        rdata_d  = rdata_q;

        if (ctrl_q[0]) begin
            if (cnt_q == PreMax) begin
                cnt_d   = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Writes override the increment; the untouched half keeps its old value.
        if (wr_en) begin
            case (word)
                AddrMtimeLo: begin
                    mtime_d = {mtime_q[63:32], bus.bus_wdata};
                    cnt_d   = '0;
                end
                AddrMtimeHi: begin
                    mtime_d = {bus.bus_wdata, mtime_q[31:0]};
                    cnt_d   = '0;
                end
                AddrCmpLo:  cmp_d  = {cmp_q[63:32], bus.bus_wdata};
                AddrCmpHi:  cmp_d  = {bus.bus_wdata, cmp_q[31:0]};
                AddrStatus: if (bus.bus_wdata[0]) pend_d = 1'b0;
                AddrCtrl:   ctrl_d = bus.bus_wdata[2:0];
                default: ;
            endcase
        end

        if (EXT_EDGE && sync2_q && !sync3_q) begin
            pend_d = 1'b1;
        end
        if (!EXT_EDGE) begin
            pend_d = 1'b0;
        end

        if (rd_en) begin
            case (word)
                AddrMtimeLo: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                AddrMtimeHi: rdata_d = shadow_q;
                AddrCmpLo:   rdata_d = cmp_q[31:0];
                AddrCmpHi:   rdata_d = cmp_q[63:32];
                AddrStatus:  rdata_d = {31'd0, ext_pend};
                AddrCtrl:    rdata_d = {29'd0, ctrl_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        irq_d = 4'd0;
        if (ext_pend && ctrl_q[2]) begin
            irq_d = 4'd2;
        end else if (tp_q && ctrl_q[1]) begin
            irq_d = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            mtime_q  <= '0;
            cmp_q    <= '1;
            shadow_q <= '0;
            ctrl_q   <= 3'b111;
            pend_q   <= 1'b0;
            tp_q     <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            ctrl_q   <= ctrl_d;
            pend_q   <= pend_d;
            tp_q     <= (mtime_q >= cmp_q);
            sync1_q  <= ext_irq;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en;
            irq_q    <= irq_d;
        end
    end

    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
    assign interrupt      = irq_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl (PRESCALE=1, edge-triggered external input).
module tb_irq_source_ctrl;

    logic       clk;
    logic       rst;
    logic       ext_irq;
    logic [3:0] interrupt;

    int total;
    int bad;

    irq_source_ctrl_if bus_if ();

    irq_source_ctrl #(
        .PRESCALE (1),
        .EXT_EDGE (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_irq   (ext_irq),
        .bus       (bus_if),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.bus_sel   = 1'b1;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        @(negedge clk);
        bus_if.bus_sel   = 1'b0;
        bus_if.bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        bus_if.bus_sel  = 1'b1;
        bus_if.bus_wr   = 1'b0;
        bus_if.bus_addr = a;
        @(negedge clk);
        bus_if.bus_sel  = 1'b0;
        d = bus_if.bus_rdata;
        v = bus_if.bus_rvalid;
    endtask

    task automatic test_reset();
        logic [31:0] d, a, b;
        logic        v, va, vb;
        rst = 1'b0;
        ext_irq = 1'b0;
        bus_if.bus_sel = 1'b0;
        bus_if.bus_wr = 1'b0;
        bus_if.bus_addr = '0;
        bus_if.bus_wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if (interrupt !== 4'd0 || bus_if.bus_rvalid !== 1'b0 || bus_if.bus_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got irq=%0d rvalid=%b rdata=%h want 0/0/0",
                     interrupt, bus_if.bus_rvalid, bus_if.bus_rdata);
        end
        rst = 1'b1;
        bus_read(5'h14, d, v);
        total++;
        if (v !== 1'b1 || d !== 32'h7) begin
            bad++;
            $display("FAIL reset_ctrl: got %h (rvalid %b) want 00000007 (1)", d, v);
        end
        @(negedge clk);
        total++;
        if (bus_if.bus_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rvalid_pulse: got %b want 0", bus_if.bus_rvalid);
        end
        bus_read(5'h08, d, v);
        total++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL reset_cmp_lo: got %h want ffffffff", d);
        end
        bus_read(5'h0C, d, v);
        total++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL reset_cmp_hi: got %h want ffffffff", d);
        end
        // Two back-to-back mtime_lo reads, one cycle apart.
        @(negedge clk);
        bus_if.bus_sel  = 1'b1;
        bus_if.bus_wr   = 1'b0;
        bus_if.bus_addr = 5'h00;
        @(negedge clk);
        a  = bus_if.bus_rdata;
        va = bus_if.bus_rvalid;
        @(negedge clk);
        b  = bus_if.bus_rdata;
        vb = bus_if.bus_rvalid;
        bus_if.bus_sel = 1'b0;
        total++;
        if (va !== 1'b1 || vb !== 1'b1 || b !== a + 32'd1) begin
            bad++;
            $display("FAIL mtime_step: got %h then %h (rvalid %b%b) want step of 1, rvalid 11",
                     a, b, va, vb);
        end
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL idle_irq: got %0d want 0", interrupt);
        end
    endtask

    task automatic test_timer();
        bus_write(5'h0C, 32'h0);
        bus_write(5'h08, 32'd20);
        bus_write(5'h00, 32'h0);
        repeat (21) @(negedge clk);
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL timer_early: got %0d want 0", interrupt);
        end
        @(negedge clk);
        total++;
        if (interrupt !== 4'd1) begin
            bad++;
            $display("FAIL timer_fire: got %0d want 1", interrupt);
        end
        bus_write(5'h08, 32'hFFFF_FFFF);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd1) begin
            bad++;
            $display("FAIL timer_hold: got %0d want 1", interrupt);
        end
        @(negedge clk);
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL timer_clear: got %0d want 0", interrupt);
        end
        bus_write(5'h0C, 32'hFFFF_FFFF);
    endtask

    task automatic test_shadow();
        logic [31:0] d;
        logic        v;
        bus_write(5'h04, 32'h0);
        bus_write(5'h00, 32'hFFFF_FFFE);
        bus_read(5'h00, d, v);
        total++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL carry_lo: got %h want ffffffff", d);
        end
        bus_read(5'h04, d, v);
        total++;
        if (d !== 32'h0) begin
            bad++;
            $display("FAIL carry_hi_shadow: got %h want 00000000", d);
        end
        bus_read(5'h00, d, v);
        total++;
        if (d !== 32'h3) begin
            bad++;
            $display("FAIL fresh_lo: got %h want 00000003", d);
        end
        bus_read(5'h04, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL fresh_hi: got %h want 00000001", d);
        end
    endtask

    task automatic test_ext_edge();
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        ext_irq = 1'b1;
        @(negedge clk);
        ext_irq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL ext_early: got %0d want 0", interrupt);
        end
        @(negedge clk);
        total++;
        if (interrupt !== 4'd2) begin
            bad++;
            $display("FAIL ext_latency: got %0d want 2", interrupt);
        end
        bus_read(5'h10, d, v);
        total++;
        if (d !== 32'h1 || interrupt !== 4'd2) begin
            bad++;
            $display("FAIL ext_sticky: got status %h irq %0d want 00000001 irq 2", d, interrupt);
        end
        bus_write(5'h10, 32'h1);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL ext_w1c: got %0d want 0", interrupt);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        logic        v;
        bus_write(5'h0C, 32'h0);
        bus_write(5'h08, 32'h0);
        @(negedge clk);
        ext_irq = 1'b1;
        @(negedge clk);
        ext_irq = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (interrupt !== 4'd2) begin
            bad++;
            $display("FAIL both_pending: got %0d want 2", interrupt);
        end
        bus_write(5'h10, 32'h1);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd1) begin
            bad++;
            $display("FAIL after_w1c_timer: got %0d want 1", interrupt);
        end
        bus_write(5'h14, 32'h1);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd0) begin
            bad++;
            $display("FAIL enable_off: got %0d want 0", interrupt);
        end
        bus_read(5'h14, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL ctrl_readback: got %h want 00000001", d);
        end
        bus_write(5'h14, 32'h3);
        @(negedge clk);
        total++;
        if (interrupt !== 4'd1) begin
            bad++;
            $display("FAIL tp_kept: got %0d want 1", interrupt);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        logic        v;
        @(negedge clk);
        ext_irq = 1'b1;
        @(negedge clk);
        ext_irq = 1'b0;
        @(negedge clk);
        // W1C lands on the same edge that sets pending.
        bus_if.bus_sel   = 1'b1;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_addr  = 5'h10;
        bus_if.bus_wdata = 32'h1;
        @(negedge clk);
        bus_if.bus_sel   = 1'b0;
        bus_if.bus_wr    = 1'b0;
        bus_read(5'h10, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL set_wins: got %h want 00000001", d);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        v;
        bus_write(5'h14, 32'h7);
        bus_read(5'h14, d, v);
        total++;
        if (interrupt !== 4'd2 || d !== 32'h7) begin
            bad++;
            $display("FAIL pre_reset: got irq %0d ctrl %h want 2 00000007", interrupt, d);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (interrupt !== 4'd0 || bus_if.bus_rdata !== 32'd0 || bus_if.bus_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got irq=%0d rdata=%h rvalid=%b want 0/0/0",
                     interrupt, bus_if.bus_rdata, bus_if.bus_rvalid);
        end
        @(negedge clk);
        rst = 1'b1;
        bus_read(5'h00, d, v);
        total++;
        if (d !== 32'h1) begin
            bad++;
            $display("FAIL post_reset_mtime: got %h want 00000001", d);
        end
        bus_read(5'h10, d, v);
        total++;
        if (d !== 32'h0 || interrupt !== 4'd0) begin
            bad++;
            $display("FAIL post_reset_pend: got status %h irq %0d want 00000000 irq 0",
                     d, interrupt);
        end
        bus_read(5'h08, d, v);
        total++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL post_reset_cmp: got %h want ffffffff", d);
        end
        bus_read(5'h18, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL reserved_read: got %h (rvalid %b) want 00000000 (1)", d, v);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_timer();
        test_shadow();
        test_ext_edge();
        test_priority();
        test_set_wins();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
